// File: rtl/rhandler_master_responder.sv
// rhandler_master_responder: splits one 64-bit master read into two 32-bit slave reads (low then high) and returns the merged R beat.
module rhandler_master_responder #(
  parameter int ADDR_W         = 20,
  parameter bit SKIP_HI_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m_araddr,
  input  logic              m_arvalid,
  output logic              m_arready,
  output logic [63:0]       m_rdata,
  output logic [1:0]        m_rresp,
  output logic              m_rvalid,
  input  logic              m_rready,
  output logic              start,
  output logic [ADDR_W-1:0] s_araddr,
  input  logic              done,
  input  logic [31:0]       s_rdata,
  input  logic [1:0]        s_rresp
);
  typedef enum logic [1:0] {WAIT_AR, RD_LO, RD_HI, SEND_R} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] base;
  logic [31:0] lo;
  logic [1:0] resp_lo;
  logic skip;
  assign skip = SKIP_HI_ON_ERR && s_rresp != 2'b00;
  // Gated by rst_n so the channel reads as not-ready while held in reset.
  assign m_arready = rst_n && state == WAIT_AR;
  always_comb begin
    state_n = state;
    case (state)
      WAIT_AR: state_n = m_arvalid ? RD_LO : WAIT_AR;
      RD_LO:   state_n = done ? (skip ? SEND_R : RD_HI) : RD_LO;
      RD_HI:   state_n = done ? SEND_R : RD_HI;
      SEND_R:  state_n = m_rready ? WAIT_AR : SEND_R;
      default: state_n = WAIT_AR;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= WAIT_AR;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base     <= '0;
      lo       <= '0;
      resp_lo  <= '0;
      start    <= 1'b0;
      s_araddr <= '0;
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
      m_rresp  <= '0;
    end else begin
      start <= 1'b0;
      case (state)
        WAIT_AR: if (m_arvalid) begin
          base     <= m_araddr & ~ADDR_W'(7);
          s_araddr <= m_araddr & ~ADDR_W'(7);
          start    <= 1'b1;
        end
        RD_LO: if (done) begin
          lo      <= s_rdata;
          resp_lo <= s_rresp;
          if (skip) begin
            m_rvalid <= 1'b1;
            m_rdata  <= {32'h0, s_rdata};
            m_rresp  <= s_rresp;
          end else begin
            start    <= 1'b1;
            s_araddr <= base + ADDR_W'(4);
          end
        end
        RD_HI: if (done) begin
          m_rvalid <= 1'b1;
          m_rdata  <= {s_rdata, lo};
          m_rresp  <= s_rresp > resp_lo ? s_rresp : resp_lo;
        end
        SEND_R: if (m_rready) m_rvalid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
